// File: rtl/pll_mdrp_pkg.sv
// Shared definitions for the PLL MDRP responder: opcodes and FSM/last-op encodings.
package pll_mdrp_pkg;

    localparam logic [1:0] MDOPC_NOP = 2'b00;
    localparam logic [1:0] MDOPC_WR  = 2'b01;
    localparam logic [1:0] MDOPC_RD  = 2'b10;
    localparam logic [1:0] MDOPC_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2
    } mdrp_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } last_op_t;

endpackage

// File: rtl/pll_lock_emu.sv
// Emulated PLL lock: a saturating settle counter that restarts on any clear
// event and raises lock LOCK_CYCLES clocks after the last clear.
module pll_lock_emu #(
    parameter int LOCK_CYCLES = 200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic lock_o
);

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    logic [15:0] cnt_q, cnt_d;
    logic        lock_q, lock_d;

    // Next-state: clear wins; otherwise count up (saturating) and latch lock at the threshold.
    always_comb begin
        cnt_d  = cnt_q;
        lock_d = lock_q;
        if (clr_i) begin
            cnt_d  = '0;
            lock_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 16'd1;
            end
            if (cnt_q >= LOCK_LAST) begin
                lock_d = 1'b1;
            end
        end
    end

    // Counter and lock registers; reset leaves the model unlocked with a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign lock_o = lock_q;

endmodule

// File: rtl/pll_mdrp_responder.sv
// Responder side of the PLL MDRP bus: command decode, 8-bit register file,
// registered read data, sticky protocol-error flag and emulated lock.
module pll_mdrp_responder
    import pll_mdrp_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int LOCK_CYCLES = 200
) (
    input  logic       mdclk,
    input  logic       reset_n,
    input  logic       pll_rst,
    input  logic [1:0] mdopc,
    input  logic       mdainc,
    input  logic [7:0] mdwdi,
    output logic [7:0] mdrdo,
    output logic       lock,
    output logic       proto_err
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    mdrp_state_t       state_q;
    last_op_t          last_op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        mdrdo_q;
    logic              proto_err_q;
    logic [7:0]        regs_q [DEPTH];
    logic              wr_commit;
    logic              lock_clr;

    // A write commits in the data cycle whatever the opcode says.
    assign wr_commit = (state_q == WR_DATA);
    assign lock_clr  = pll_rst | wr_commit;

    // Command decoder FSM with registered read data and sticky error flag.
    always_ff @(posedge mdclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_op_q   <= NONE;
            addr_q      <= '0;
            mdrdo_q     <= 8'h00;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (mdopc)
                        MDOPC_WR: begin
                            addr_q    <= mdwdi[ADDR_W-1:0];
                            last_op_q <= WR;
                            state_q   <= WR_DATA;
                        end
                        MDOPC_RD: begin
                            addr_q    <= mdwdi[ADDR_W-1:0];
                            last_op_q <= RD;
                            state_q   <= RD_DATA;
                        end
                        MDOPC_RSV: begin
                            proto_err_q <= 1'b1;
                        end
                        default: begin
                            // Increment-and-repeat only makes sense once an op has been seen.
                            if (mdainc && (last_op_q != NONE)) begin
                                addr_q  <= addr_q + ADDR_ONE;
                                state_q <= (last_op_q == WR) ? WR_DATA : RD_DATA;
                            end
                        end
                    endcase
                end
                WR_DATA: begin
                    if (mdopc != MDOPC_NOP) begin
                        proto_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                RD_DATA: begin
                    mdrdo_q <= regs_q[addr_q];
                    if (mdopc != MDOPC_NOP) begin
                        proto_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register file; async reset clears every entry so an aborted write leaves nothing behind.
    always_ff @(posedge mdclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_commit) begin
            regs_q[addr_q] <= mdwdi;
        end
    end

    pll_lock_emu #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock (
        .clk_i  (mdclk),
        .rst_ni (reset_n),
        .clr_i  (lock_clr),
        .lock_o (lock)
    );

    assign mdrdo     = mdrdo_q;
    assign proto_err = proto_err_q;

endmodule

// File: doc/pll_mdrp_responder.md
Name: pll_mdrp_responder

Overview:
- Responder end of the PLL MDRP (dynamic reconfiguration) bus: decodes mdopc/mdainc/mdwdi from the PLL initialisation controller, maintains an 8-bit register file and returns read data on mdrdo.
- Emulates PLL lock behaviour (lock drops on reconfiguration or PLL reset, re-asserts after a settle count).
- Used as a behavioural PLL configuration-space model for simulation and as a soft configuration target where no hard MDRP exists.

Parameters:
- ADDR_W, 5, register-file address width; depth = 2**ADDR_W.
- LOCK_CYCLES, 200, mdclk cycles from a lock-clearing event to lock re-asserting; legal range 1..65535.

Ports:
- mdclk  input  1  MDRP clock, rising-edge.
- reset_n  input  1  async active-low reset.
- pll_rst  input  1  PLL reset from initiator, active-high, synchronous to mdclk.
- mdopc  input  2  opcode: 00 NOP, 01 WRITE, 10 READ, 11 reserved.
- mdainc  input  1  address-increment / repeat-last-op strobe.
- mdwdi  input  8  address in command cycle; data in write-data cycle.
- mdrdo  output  8  registered read data.
- lock  output  1  emulated PLL lock.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_n low, async): all regs 8'h00, addr 0, last_op NONE, state IDLE, mdrdo 8'h00, lock 0, proto_err 0, lock counter 0.
- State IDLE:
  - opc 01: addr<=mdwdi[ADDR_W-1:0], last_op<=WR, go WR_DATA.
  - opc 10: addr<=mdwdi[ADDR_W-1:0], last_op<=RD, go RD_DATA.
  - opc 11: proto_err<=1, stay IDLE.
  - opc 00 with mdainc 1: addr<=addr+1 (modulo depth, wraps to 0); WR->WR_DATA, RD->RD_DATA, NONE->ignored, stay IDLE.
  - opc has priority over mdainc when both are active; mdainc is ignored in that case.
- State WR_DATA: regs[addr]<=mdwdi; clear lock; go IDLE. A nonzero opc in this cycle sets proto_err; the write still commits and the opc is discarded.
- State RD_DATA: mdrdo<=regs[addr]; go IDLE. mdrdo is visible after the 2nd rising edge following address presentation and holds until the next read. A nonzero opc here sets proto_err and is discarded.
- Throughput: one op per 2 cycles. Back-to-back ops are legal from IDLE only.
- Lock:
  - Counter clears and lock<=0 on any of: pll_rst high, write commit, or exit from reset.
  - Otherwise the counter increments, saturating. lock<=1 once counter==LOCK_CYCLES-1.
  - While pll_rst is held high, lock stays 0. The MDRP decode is unaffected by pll_rst.
- proto_err clears only on reset_n.
- Reset mid-operation aborts any pending write or read; no partial register update.

Decomposition:
- Shared package pll_mdrp_pkg:
  - opcode constants MDOPC_NOP/WR/RD/RSV.
  - enum mdrp_state_t {IDLE, WR_DATA, RD_DATA}.
  - enum last_op_t {NONE, WR, RD}.
- Sub-module pll_lock_emu: counter, lock output, clear inputs, LOCK_CYCLES parameter.
- Register file and decoder stay in the top module.

Test Plan:
- Write then read back:
  - Stimulus: opc01 wdi 0x03, then wdi 0xA5; opc10 wdi 0x03, NOP.
  - Response: mdrdo=0xA5 after the 2nd edge; lock drops at the write and re-asserts exactly LOCK_CYCLES cycles later.
- Auto-increment write with wrap (ADDR_W=5):
  - Stimulus: write 0x11 to addr 0x1F, then mdainc with wdi 0x22.
  - Response: reading addr 0x00 returns 0x22 and addr 0x1F returns 0x11.
- Auto-increment read burst:
  - Stimulus: regs 4..6 = 0x40,0x50,0x60; read addr 4, then two mdainc strobes 2 cycles apart.
  - Response: mdrdo sequence 0x40,0x50,0x60.
- Protocol errors:
  - Stimulus: opc11 in IDLE, then separately opc10 during WR_DATA.
  - Response: proto_err=1 and sticky; the write still commits; the stray read is not executed; mdainc with last_op NONE after reset changes nothing.
- PLL reset and lock:
  - Stimulus: after lock=1, pulse pll_rst high for 5 cycles.
  - Response: lock=0 the cycle after pll_rst rises, re-asserts LOCK_CYCLES cycles after pll_rst falls; register contents unchanged.
- Async reset mid-write:
  - Stimulus: assert reset_n low in WR_DATA with wdi 0xFF.
  - Response: outputs at reset values immediately; the target register reads 0x00 after release.
